aq_djpeg_mcu_sched: RTL and testbench

- Per-block scheduler for the baseline decode path.
- After the header parser has loaded the frame geometry and raised ImageEnable, it walks the image in MCU order.
- For each 8x8 block it issues one descriptor to the Huffman/IDCT datapath: component, block index within the MCU, MCU X/Y.
- It waits for the datapath to finish that block before issuing the next, and pulses Done after the last block of the image.

---
 rtl/aq_djpeg_mcu_sched_pkg.sv | 21 ++
 rtl/aq_djpeg_mcu_pos.sv | 86 ++++++++
 rtl/aq_djpeg_mcu_sched.sv | 180 ++++++++++++++++++
 tb/tb_aq_djpeg_mcu_sched.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_djpeg_mcu_sched_pkg.sv
// Shared definitions for the baseline MCU scheduler: component codes,
// scheduler states and the grey block-unit size.
package aq_djpeg_mcu_sched_pkg;

   localparam logic [1:0] COMP_Y  = 2'd0;
   localparam logic [1:0] COMP_CB = 2'd1;
   localparam logic [1:0] COMP_CR = 2'd2;

   // A grey MCU is one 32x8 strip of four luma blocks
   localparam int unsigned GREY_UNIT = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_NEXT,
      ST_FIN,
      ST_RST
   } state_t;

endpackage

// File: rtl/aq_djpeg_mcu_pos.sv
// Block / MCU column / MCU row position counters for the MCU scheduler,
// including the descriptor decode and the last-in-MCU / last-in-image flags.
module aq_djpeg_mcu_pos
   import aq_djpeg_mcu_sched_pkg::*;
#(
   parameter int BW = 12
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clear,
   input  logic          i_advance,
   input  logic          i_colour,
   input  logic          i_wf2,
   input  logic          i_hf2,
   input  logic [BW-1:0] i_width,
   input  logic [BW-1:0] i_height,
   output logic [1:0]    o_comp,
   output logic [1:0]    o_index,
   output logic [BW-1:0] o_mcuX,
   output logic [BW-1:0] o_mcuY,
   output logic          o_lastInMcu,
   output logic          o_lastInImage
);

   logic [2:0]    r_blk;
   logic [BW-1:0] r_mcuX;
   logic [BW-1:0] r_mcuY;
   logic [2:0]    w_numY;
   logic          w_lastCol;
   logic          w_lastRow;

   always_comb begin
      case ({i_wf2, i_hf2})
         2'b11:   w_numY = 3'd4;
         2'b00:   w_numY = 3'd1;
         default: w_numY = 3'd2;
      endcase
   end

   // Colour MCUs carry the luma blocks first, then one Cb and one Cr block
   always_comb begin
      o_comp  = COMP_Y;
      o_index = r_blk[1:0];
      if (i_colour && (r_blk == w_numY)) begin
         o_comp  = COMP_CB;
         o_index = 2'd0;
      end else if (i_colour && (r_blk == w_numY + 3'd1)) begin
         o_comp  = COMP_CR;
         o_index = 2'd0;
      end
   end

   assign o_lastInMcu   = i_colour ? (r_blk == w_numY + 3'd1)
                                   : (r_blk == 3'(GREY_UNIT - 1));
   assign w_lastCol     = (r_mcuX == i_width - BW'(1));
   assign w_lastRow     = (r_mcuY == i_height - BW'(1));
   assign o_lastInImage = o_lastInMcu & w_lastCol & w_lastRow;
   assign o_mcuX        = r_mcuX;
   assign o_mcuY        = r_mcuY;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_blk  <= '0;
         r_mcuX <= '0;
         r_mcuY <= '0;
      end else if (i_clear) begin
         r_blk  <= '0;
         r_mcuX <= '0;
         r_mcuY <= '0;
      end else if (i_advance) begin
         if (o_lastInMcu) begin
            r_blk <= '0;
            if (w_lastCol) begin
               r_mcuX <= '0;
               r_mcuY <= r_mcuY + BW'(1);
            end else begin
               r_mcuX <= r_mcuX + BW'(1);
            end
         end else begin
            r_blk <= r_blk + 3'd1;
         end
      end
   end

endmodule

// File: rtl/aq_djpeg_mcu_sched.sv
// Per-block scheduler: walks the frame in MCU order, issuing one descriptor per
// 8x8 block and waiting for completion. Optional restart-interval support via AQ_DJPEG_MCU_RESTART_EN.
module aq_djpeg_mcu_sched
   import aq_djpeg_mcu_sched_pkg::*;
#(
   parameter int BW  = 12,
   parameter int RIW = 16
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic           Start,
   input  logic           Abort,
   input  logic [2:0]     JpegComp,
   input  logic [1:0]     SubSamplingW,
   input  logic [1:0]     SubSamplingH,
   input  logic [BW-1:0]  BlockWidth,
   input  logic [BW-1:0]  BlockHeight,
   output logic           BlkValid,
   input  logic           BlkReady,
   output logic [1:0]     BlkComp,
   output logic [1:0]     BlkIndex,
   output logic [BW-1:0]  McuX,
   output logic [BW-1:0]  McuY,
   output logic           BlkLastInMcu,
   output logic           BlkLastInImage,
   input  logic           BlkDone,
   output logic           Busy,
   output logic           Done
`ifdef AQ_DJPEG_MCU_RESTART_EN
   ,
   input  logic [RIW-1:0] RestartInterval,
   output logic           RestartReq,
   input  logic           RestartAck
`endif
);

   state_t        r_state;
   state_t        w_stateNext;
   logic          r_colour;
   logic          r_wf2;
   logic          r_hf2;
   logic [BW-1:0] r_width;
   logic [BW-1:0] r_height;
   logic          w_start;
   logic          w_clear;
   logic          w_lastInMcu;
   logic          w_lastInImage;

   assign w_start = (r_state == ST_IDLE) && Start;
   assign w_clear = Abort | w_start;

   // Geometry is captured once per frame so the header parser may move on
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_colour <= 1'b0;
         r_wf2    <= 1'b0;
         r_hf2    <= 1'b0;
         r_width  <= '0;
         r_height <= '0;
      end else if (w_start) begin
         r_colour <= (JpegComp == 3'd3);
         r_wf2    <= (SubSamplingW == 2'd2);
         r_hf2    <= (SubSamplingH == 2'd2);
         r_width  <= BlockWidth;
         r_height <= BlockHeight;
      end
   end

   aq_djpeg_mcu_pos #(.BW(BW)) u_pos (
      .clk           (clk),
      .rst           (rst),
      .i_clear       (w_clear),
      .i_advance     (r_state == ST_NEXT),
      .i_colour      (r_colour),
      .i_wf2         (r_wf2),
      .i_hf2         (r_hf2),
      .i_width       (r_width),
      .i_height      (r_height),
      .o_comp        (BlkComp),
      .o_index       (BlkIndex),
      .o_mcuX        (McuX),
      .o_mcuY        (McuY),
      .o_lastInMcu   (w_lastInMcu),
      .o_lastInImage (w_lastInImage)
   );

`ifdef AQ_DJPEG_MCU_RESTART_EN
   logic [RIW-1:0] r_restartInt;
   logic [RIW-1:0] r_mcuCnt;
   logic [RIW-1:0] w_mcuCntInc;
   logic           w_mcuDone;
   logic           w_restartHit;

   assign w_mcuCntInc  = r_mcuCnt + RIW'(1);
   assign w_mcuDone    = (r_state == ST_NEXT) && w_lastInMcu && !w_lastInImage;
   assign w_restartHit = w_mcuDone && (r_restartInt != '0) && (w_mcuCntInc == r_restartInt);
   assign RestartReq   = (r_state == ST_RST);

   // The MCU count restarts at each interval boundary; no restart after the final MCU
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_restartInt <= '0;
         r_mcuCnt     <= '0;
      end else begin
         if (w_start) begin
            r_restartInt <= RestartInterval;
         end
         if (w_clear) begin
            r_mcuCnt <= '0;
         end else if (w_mcuDone) begin
            r_mcuCnt <= w_restartHit ? '0 : w_mcuCntInc;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_stateNext = ((BlockWidth == '0) || (BlockHeight == '0)) ? ST_FIN : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (BlkReady) begin
               w_stateNext = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (BlkDone) begin
               w_stateNext = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (w_lastInImage) begin
               w_stateNext = ST_FIN;
`ifdef AQ_DJPEG_MCU_RESTART_EN
            end else if (w_restartHit) begin
               w_stateNext = ST_RST;
`endif
            end else begin
               w_stateNext = ST_ISSUE;
            end
         end
         ST_FIN: begin
            w_stateNext = ST_IDLE;
         end
`ifdef AQ_DJPEG_MCU_RESTART_EN
         ST_RST: begin
            if (RestartAck) begin
               w_stateNext = ST_ISSUE;
            end
         end
`endif
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
      if (Abort) begin
         w_stateNext = ST_IDLE;
      end
   end

   assign BlkValid       = (r_state == ST_ISSUE);
   assign BlkLastInMcu   = BlkValid & w_lastInMcu;
   assign BlkLastInImage = BlkValid & w_lastInImage;
   assign Busy           = (r_state != ST_IDLE);
   assign Done           = (r_state == ST_FIN);

endmodule

// File: tb/tb_aq_djpeg_mcu_sched.sv
// Self-checking bench for aq_djpeg_mcu_sched: a queue-based model of the block
// walk drives a per-cycle protocol checker under randomized handshakes.
module tb_aq_djpeg_mcu_sched;

   localparam int BW  = 12;
   localparam int RIW = 16;

   localparam int M_PRESENT = 0;
   localparam int M_BUSY    = 1;
   localparam int M_GAP     = 2;
   localparam int M_RST     = 3;
   localparam int M_FIN     = 4;
   localparam int M_POST    = 5;
   localparam int M_ABORT   = 6;

   logic          clk          = 1'b0;
   logic          rst          = 1'b0;
   logic          Start        = 1'b0;
   logic          Abort        = 1'b0;
   logic [2:0]    JpegComp     = '0;
   logic [1:0]    SubSamplingW = '0;
   logic [1:0]    SubSamplingH = '0;
   logic [BW-1:0] BlockWidth   = '0;
   logic [BW-1:0] BlockHeight  = '0;
   logic          BlkReady     = 1'b0;
   logic          BlkDone      = 1'b0;
   logic          BlkValid;
   logic [1:0]    BlkComp;
   logic [1:0]    BlkIndex;
   logic [BW-1:0] McuX;
   logic [BW-1:0] McuY;
   logic          BlkLastInMcu;
   logic          BlkLastInImage;
   logic          Busy;
   logic          Done;
`ifdef AQ_DJPEG_MCU_RESTART_EN
   logic [RIW-1:0] RestartInterval = '0;
   logic           RestartReq;
   logic           RestartAck      = 1'b0;
`endif

   typedef struct {
      int comp;
      int idx;
      int x;
      int y;
      bit lastMcu;
      bit lastImg;
      bit restartAfter;
   } desc_t;

   desc_t expQ[$];
   desc_t seen[$];
   int    testsRun    = 0;
   int    testsFailed = 0;

   always #5 clk = ~clk;

   aq_djpeg_mcu_sched #(.BW(BW), .RIW(RIW)) dut (
      .clk             (clk),
      .rst             (rst),
      .Start           (Start),
      .Abort           (Abort),
      .JpegComp        (JpegComp),
      .SubSamplingW    (SubSamplingW),
      .SubSamplingH    (SubSamplingH),
      .BlockWidth      (BlockWidth),
      .BlockHeight     (BlockHeight),
      .BlkValid        (BlkValid),
      .BlkReady        (BlkReady),
      .BlkComp         (BlkComp),
      .BlkIndex        (BlkIndex),
      .McuX            (McuX),
      .McuY            (McuY),
      .BlkLastInMcu    (BlkLastInMcu),
      .BlkLastInImage  (BlkLastInImage),
      .BlkDone         (BlkDone),
      .Busy            (Busy),
      .Done            (Done)
`ifdef AQ_DJPEG_MCU_RESTART_EN
      ,
      .RestartInterval (RestartInterval),
      .RestartReq      (RestartReq),
      .RestartAck      (RestartAck)
`endif
   );

   // One comparison: counts it, and reports it when the values differ
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkRestart(input int expected);
`ifdef AQ_DJPEG_MCU_RESTART_EN
      checkOutput("restartReq", RestartReq, expected);
`endif
   endtask

   // Expected block list of a frame, built from the MCU layout rules
   task automatic buildModel(input int comp, input int sw, input int sh,
                             input int w, input int h, input int ri);
      int    pat[$];
      int    wf;
      int    hf;
      int    mcu;
      desc_t d;
      expQ.delete();
      wf = (sw == 2) ? 2 : 1;
      hf = (sh == 2) ? 2 : 1;
      if (comp == 3) begin
         for (int i = 0; i < wf * hf; i++) pat.push_back(i);
         pat.push_back(4);
         pat.push_back(8);
      end else begin
         for (int i = 0; i < 4; i++) pat.push_back(i);
      end
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            mcu = y * w + x;
            for (int k = 0; k < pat.size(); k++) begin
               d.comp         = pat[k] / 4;
               d.idx          = pat[k] % 4;
               d.x            = x;
               d.y            = y;
               d.lastMcu      = (k == pat.size() - 1);
               d.lastImg      = d.lastMcu && (x == w - 1) && (y == h - 1);
               d.restartAfter = d.lastMcu && !d.lastImg && (ri != 0) && (((mcu + 1) % ri) == 0);
               expQ.push_back(d);
            end
         end
      end
   endtask

   // Runs one frame: drives the datapath side and checks every cycle
   task automatic applyStimulus(input int comp, input int sw, input int sh, input int w,
                                input int h, input int ri, input int abortAt, input int stallN);
      int    idx;
      int    mode;
      int    dcount;
      int    hold;
      int    cyc;
      int    stall;
      bit    finished;
      bit    rdy;
      desc_t d;
      buildModel(comp, sw, sh, w, h, ri);
      seen.delete();
      @(negedge clk);
      JpegComp     = 3'(comp);
      SubSamplingW = 2'(sw);
      SubSamplingH = 2'(sh);
      BlockWidth   = BW'(w);
      BlockHeight  = BW'(h);
`ifdef AQ_DJPEG_MCU_RESTART_EN
      RestartInterval = RIW'(ri);
`endif
      Start = 1'b1;
      @(negedge clk);
      Start        = 1'b0;
      JpegComp     = 3'($urandom);
      SubSamplingW = 2'($urandom);
      SubSamplingH = 2'($urandom);
      BlockWidth   = BW'($urandom_range(0, 7));
      BlockHeight  = BW'($urandom_range(0, 7));
      idx      = 0;
      dcount   = 0;
      hold     = 0;
      cyc      = 0;
      stall    = 0;
      finished = 1'b0;
      mode     = (expQ.size() == 0) ? M_FIN : M_PRESENT;
      while (!finished && cyc < 3000) begin
         BlkDone = 1'b0;
         Abort   = 1'b0;
`ifdef AQ_DJPEG_MCU_RESTART_EN
         RestartAck = 1'b0;
`endif
         rdy = ($urandom_range(0, 3) != 0);
         case (mode)
            M_PRESENT: begin
               checkOutput("valid", BlkValid, 1);
               checkOutput("done", Done, 0);
               checkOutput("busy", Busy, 1);
               checkRestart(0);
               checkOutput("comp", BlkComp, expQ[idx].comp);
               checkOutput("index", BlkIndex, expQ[idx].idx);
               checkOutput("mcuX", McuX, expQ[idx].x);
               checkOutput("mcuY", McuY, expQ[idx].y);
               checkOutput("lastInMcu", BlkLastInMcu, expQ[idx].lastMcu);
               checkOutput("lastInImage", BlkLastInImage, expQ[idx].lastImg);
               if (stall < stallN) begin
                  rdy     = 1'b0;
                  BlkDone = 1'b1;
                  stall++;
               end else if ($urandom_range(0, 3) == 0) begin
                  BlkDone = 1'b1;
               end
               if (rdy) begin
                  d.comp    = BlkComp;
                  d.idx     = BlkIndex;
                  d.x       = McuX;
                  d.y       = McuY;
                  d.lastMcu = BlkLastInMcu;
                  d.lastImg = BlkLastInImage;
                  seen.push_back(d);
                  idx++;
                  dcount = $urandom_range(0, 3);
                  mode   = M_BUSY;
               end
            end
            M_BUSY: begin
               checkOutput("validWait", BlkValid, 0);
               checkOutput("doneWait", Done, 0);
               checkOutput("busyWait", Busy, 1);
               checkRestart(0);
               if (abortAt == idx) begin
                  Abort = 1'b1;
                  mode  = M_ABORT;
               end else if (dcount == 0) begin
                  BlkDone = 1'b1;
                  mode    = M_GAP;
               end else begin
                  dcount--;
               end
            end
            M_GAP: begin
               checkOutput("validGap", BlkValid, 0);
               checkOutput("doneGap", Done, 0);
               checkOutput("busyGap", Busy, 1);
               checkRestart(0);
               if (idx == expQ.size()) begin
                  mode = M_FIN;
               end else if (expQ[idx - 1].restartAfter) begin
                  hold = $urandom_range(0, 4);
                  mode = M_RST;
               end else begin
                  mode = M_PRESENT;
               end
            end
            M_RST: begin
`ifdef AQ_DJPEG_MCU_RESTART_EN
               checkRestart(1);
               checkOutput("validRst", BlkValid, 0);
               checkOutput("busyRst", Busy, 1);
               if (hold == 0) begin
                  RestartAck = 1'b1;
                  mode       = M_PRESENT;
               end else begin
                  hold--;
               end
`else
               mode = M_PRESENT;
`endif
            end
            M_FIN: begin
               checkOutput("donePulse", Done, 1);
               checkOutput("validFin", BlkValid, 0);
               checkOutput("busyFin", Busy, 1);
               checkRestart(0);
               mode = M_POST;
            end
            M_POST: begin
               checkOutput("doneCleared", Done, 0);
               checkOutput("busyIdle", Busy, 0);
               checkOutput("validIdle", BlkValid, 0);
               finished = 1'b1;
            end
            default: begin
               checkOutput("validAbort", BlkValid, 0);
               checkOutput("busyAbort", Busy, 0);
               checkOutput("doneAbort", Done, 0);
               finished = 1'b1;
            end
         endcase
         BlkReady = rdy;
         cyc++;
         if (!finished) @(negedge clk);
      end
      if (!finished) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL frameTimeout: got no completion after %0d cycles, expected completion", cyc);
      end
      BlkReady = 1'b0;
      BlkDone  = 1'b0;
      Abort    = 1'b0;
   endtask

   initial begin
      int lit420[6];
      int comp;
      int ri;
      lit420 = '{0, 1, 2, 3, 4, 8};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstValid", BlkValid, 0);
      checkOutput("rstBusy", Busy, 0);
      checkOutput("rstDone", Done, 0);
      checkOutput("rstComp", BlkComp, 0);
      checkOutput("rstIndex", BlkIndex, 0);
      checkOutput("rstMcuX", McuX, 0);
      checkOutput("rstMcuY", McuY, 0);
      checkOutput("rstLastMcu", BlkLastInMcu, 0);
      checkOutput("rstLastImg", BlkLastInImage, 0);
      rst = 1'b1;

      // 4:2:0 single MCU; the block order is pinned literally as well
      applyStimulus(3, 2, 2, 1, 1, 0, -1, 0);
      checkOutput("count420", seen.size(), 6);
      for (int i = 0; i < seen.size() && i < 6; i++) begin
         checkOutput("seq420", seen[i].comp * 4 + seen[i].idx, lit420[i]);
         checkOutput("lastImg420", seen[i].lastImg, (i == 5) ? 1 : 0);
      end

      // Grey 2x1
      applyStimulus(1, 0, 0, 2, 1, 0, -1, 0);
      checkOutput("countGrey", seen.size(), 8);
      if (seen.size() == 8) begin
         checkOutput("greyX3", seen[3].x, 0);
         checkOutput("greyX4", seen[4].x, 1);
         checkOutput("greyIdx4", seen[4].idx, 0);
      end

      // 4:4:4 2x2
      applyStimulus(3, 1, 1, 2, 2, 0, -1, 0);
      checkOutput("count444", seen.size(), 12);
      if (seen.size() == 12) begin
         checkOutput("x444b3", seen[3].x, 1);
         checkOutput("y444b6", seen[6].y, 1);
         checkOutput("x444b6", seen[6].x, 0);
         checkOutput("y444b11", seen[11].y, 1);
      end

      // Backpressure with spurious BlkDone while the descriptor is held
      applyStimulus(3, 2, 1, 1, 1, 0, -1, 5);

      // Abort during WAIT of the third accepted block, then a clean restart
      applyStimulus(3, 2, 2, 2, 2, 0, 3, 0);
      applyStimulus(3, 2, 2, 1, 1, 0, -1, 0);

      // Zero-sized frames finish with no descriptor
      applyStimulus(3, 2, 2, 0, 3, 0, -1, 0);
      applyStimulus(1, 0, 0, 2, 0, 0, -1, 0);

`ifdef AQ_DJPEG_MCU_RESTART_EN
      applyStimulus(3, 2, 1, 2, 1, 1, -1, 0);
`endif

      for (int r = 0; r < 8; r++) begin
         comp = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 7));
         ri = 0;
`ifdef AQ_DJPEG_MCU_RESTART_EN
         ri = $urandom_range(0, 3);
`endif
         applyStimulus(comp, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), ri, -1, $urandom_range(0, 2));
      end

      // Asynchronous reset in the middle of a frame
      @(negedge clk);
      JpegComp     = 3'd3;
      SubSamplingW = 2'd2;
      SubSamplingH = 2'd2;
      BlockWidth   = BW'(2);
      BlockHeight  = BW'(2);
      Start        = 1'b1;
      @(negedge clk);
      Start    = 1'b0;
      BlkReady = 1'b1;
      @(negedge clk);
      checkOutput("midBusy", Busy, 1);
      #2 rst = 1'b0;
      #1;
      checkOutput("midRstBusy", Busy, 0);
      checkOutput("midRstValid", BlkValid, 0);
      checkOutput("midRstDone", Done, 0);
      @(negedge clk);
      rst      = 1'b1;
      BlkReady = 1'b0;
      applyStimulus(3, 2, 2, 1, 1, 0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
